// File: rtl/load_store_unit.sv
// Handshaked load/store engine: lane shifting, byte masks, load extension, optional two-beat split.
// Aligned access: accept -> rsp_valid 3 cycles later (+2 if split); req_ready only in IDLE, mem port held until mem_gnt.
module load_store_unit #(
   parameter int XLEN     = 32,
   parameter bit SPLIT_EN = 1'b1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_we,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_addr,
   input  logic [XLEN-1:0] req_wdata,
   output logic            rsp_valid,
   output logic [XLEN-1:0] rsp_rdata,
   output logic            rsp_err,
   output logic            mem_req,
   input  logic            mem_gnt,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [XLEN-1:0] mem_wdata,
   output logic [XLEN/8-1:0] mem_wmask,
   input  logic            mem_rvalid,
   input  logic [XLEN-1:0] mem_rdata
);
   localparam int B  = XLEN / 8;
   localparam int OW = $clog2(B);
   localparam int XW = $clog2(XLEN);

   typedef enum logic [2:0] {IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP} state_t;

   state_t              r_state;
   logic                r_we;
   logic                r_uns;
   logic                r_cross;
   logic [3:0]          r_nbytes;
   logic [OW-1:0]       r_off;
   logic [XLEN-1:0]     r_addr_al;
   logic [XLEN-1:0]     r_rd0;
   logic [2*XLEN-1:0]   r_wvec;
   logic [2*B-1:0]      r_mvec;

   // Request decode, evaluated on the incoming request while IDLE
   logic [OW-1:0]       w_off;
   logic [3:0]          w_nbytes;
   logic [4:0]          w_end;
   logic                w_cross;
   logic                w_illegal;
   logic [2*B-1:0]      w_ones;
   logic [2*B-1:0]      w_mvec;
   logic [2*XLEN-1:0]   w_wvec;
   logic [XLEN-1:0]     w_addr_al;

   assign w_off     = req_addr[OW-1:0];
   assign w_nbytes  = 4'd1 << req_size;
   assign w_end     = 5'(w_off) + 5'(w_nbytes);
   assign w_cross   = w_end > 5'(B);
   assign w_illegal = (XLEN == 32) && (req_size == 2'b11);
   assign w_ones    = ~({(2*B){1'b1}} << w_nbytes);
   assign w_mvec    = req_we ? (w_ones << w_off) : '0;
   assign w_wvec    = req_we ? ({{XLEN{1'b0}}, req_wdata} << {w_off, 3'b000}) : '0;
   assign w_addr_al = {req_addr[XLEN-1:OW], {OW{1'b0}}};

   // Load alignment: second beat supplies the upper word only in WAIT1
   logic [2*XLEN-1:0]   w_rpair;
   logic [XLEN-1:0]     w_rlo;
   logic [6:0]          w_nbits;
   logic [XLEN-1:0]     w_lmask;
   logic [XW-1:0]       w_sidx;
   logic                w_sign;
   logic [XLEN-1:0]     w_ext;

   assign w_rpair = (r_state == WAIT1) ? {mem_rdata, r_rd0} : {{XLEN{1'b0}}, mem_rdata};
   assign w_rlo   = XLEN'(w_rpair >> {r_off, 3'b000});
   assign w_nbits = {r_nbytes, 3'b000};
   assign w_lmask = ~({XLEN{1'b1}} << w_nbits);
   assign w_sidx  = XW'(w_nbits - 7'd1);
   assign w_sign  = ~r_uns & w_rlo[w_sidx];
   assign w_ext   = (w_rlo & w_lmask) | ({XLEN{w_sign}} & ~w_lmask);

   assign req_ready = (r_state == IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= IDLE;
         r_we      <= 1'b0;
         r_uns     <= 1'b0;
         r_cross   <= 1'b0;
         r_nbytes  <= 4'd0;
         r_off     <= '0;
         r_addr_al <= '0;
         r_rd0     <= '0;
         r_wvec    <= '0;
         r_mvec    <= '0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wmask <= '0;
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (req_valid) begin
                  r_we      <= req_we;
                  r_uns     <= req_unsigned;
                  r_cross   <= w_cross;
                  r_nbytes  <= w_nbytes;
                  r_off     <= w_off;
                  r_addr_al <= w_addr_al;
                  r_wvec    <= w_wvec;
                  r_mvec    <= w_mvec;
                  if (w_illegal || (w_cross && !SPLIT_EN)) begin
                     r_state   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                  end else begin
                     r_state   <= REQ0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= w_addr_al;
                     mem_wdata <= w_wvec[XLEN-1:0];
                     mem_wmask <= w_mvec[B-1:0];
                  end
               end
            end
            REQ0, REQ1: begin
               if (mem_gnt) begin
                  mem_req <= 1'b0;
                  r_state <= (r_state == REQ0) ? WAIT0 : WAIT1;
               end
            end
            WAIT0: begin
               if (mem_rvalid) begin
                  r_rd0 <= mem_rdata;
                  if (r_cross) begin
                     r_state   <= REQ1;
                     mem_req   <= 1'b1;
                     mem_addr  <= r_addr_al + XLEN'(B);
                     mem_wdata <= r_wvec[2*XLEN-1:XLEN];
                     mem_wmask <= r_mvec[2*B-1:B];
                  end else begin
                     r_state   <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b0;
                     rsp_rdata <= r_we ? '0 : w_ext;
                  end
               end
            end
            WAIT1: begin
               if (mem_rvalid) begin
                  r_state   <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_err   <= 1'b0;
                  rsp_rdata <= r_we ? '0 : w_ext;
               end
            end
            RESP: begin
               r_state   <= IDLE;
               rsp_valid <= 1'b0;
               rsp_err   <= 1'b0;
               rsp_rdata <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule
